clk_div_bank: RTL

- Parametrised, runtime-reconfigurable successor to the fixed-ratio PLL wrapper.
- Generates NCH independent divided clock-level signals plus one-cycle rising-edge ticks from a single fabric clock.
- Each channel has programmable period, high time, phase and enable, with a PLL-style lock flag per channel.
- Sits behind the PLL output and feeds SoC peripherals (UART, timers, sampling strobes); configured from a CSR block.

---
 rtl/clk_div_bank.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/clk_div_bank.sv
// clk_div_bank
// Runtime-reconfigurable bank of NCH clock dividers driven from one fabric clock.
// Each channel produces a divided clock level, a one-cycle tick at the start of
// every period, and a lock flag that rises once a new configuration has run
// for LOCK_CYCLES enabled cycles.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   cfg_valid  configuration write request
//   cfg_ready  write can be accepted for cfg_ch (combinational)
//   cfg_ch     target channel; out-of-range values are accepted and dropped
//   cfg_div    period in clk cycles (0 and 1 both mean 1)
//   cfg_high   high cycles per period (>= period gives a constant-high level)
//   cfg_phase  counter start value on apply or sync (>= period means 0)
//   cfg_en     channel enable
//   sync_i     restart every enabled channel counter at its phase
//   ch_clk     divided clock levels (registered)
//   ch_tick    one-cycle pulse per period (registered)
//   lock       channel configuration settled
module clk_div_bank #(
    parameter int NCH         = 4,
    parameter int DIV_W       = 16,
    parameter int LOCK_CYCLES = 8,
    parameter int DEF_DIV     = 2,
    parameter int RESET_EN    = 1,
    localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_high,
    input  logic [DIV_W-1:0] cfg_phase,
    input  logic             cfg_en,
    input  logic             sync_i,
    output logic [NCH-1:0]   ch_clk,
    output logic [NCH-1:0]   ch_tick,
    output logic [NCH-1:0]   lock
);

    localparam int            LK_W      = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;
    localparam logic [LK_W-1:0] LOCK_INIT = LK_W'(LOCK_CYCLES);

    logic [NCH-1:0]   pend;
    logic [DIV_W-1:0] norm_div;
    logic [DIV_W-1:0] norm_phase;

    // A channel can take a new write only once its previous one has been
    // applied; writes to channels that do not exist are always swallowed.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pend[i];
            end
        end
    end

    // Fields are cleaned up once at accept time so the counters never see a
    // zero period or a start value outside the period.
    always_comb begin
        norm_div   = (cfg_div <= DIV_W'(1)) ? DIV_W'(1) : cfg_div;
        norm_phase = (cfg_phase >= norm_div) ? '0 : cfg_phase;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [DIV_W-1:0] div_a, high_a, phase_a;
        logic [DIV_W-1:0] div_p, high_p, phase_p;
        logic [DIV_W-1:0] cnt;
        logic [LK_W-1:0]  lock_cnt;
        logic             en_a, en_p, pend_r;
        logic             clk_r, tick_r, lock_r;
        logic             accept, at_boundary, apply;

        assign accept      = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));
        assign at_boundary = (cnt == div_a - DIV_W'(1));
        // Swapping only at the end of a period keeps the output free of
        // runt pulses; an idle channel has no period to protect.
        assign apply       = pend_r && (!en_a || at_boundary);

        assign ch_clk[g]  = clk_r;
        assign ch_tick[g] = tick_r;
        assign lock[g]    = lock_r;
        assign pend[g]    = pend_r;

        // Per-channel divider: pending/active config, counter, outputs and lock.
        // Outputs are decoded from the counter value before this edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                div_a    <= DIV_W'(DEF_DIV);
                high_a   <= DIV_W'(DEF_DIV / 2);
                phase_a  <= '0;
                en_a     <= (RESET_EN != 0);
                div_p    <= DIV_W'(DEF_DIV);
                high_p   <= DIV_W'(DEF_DIV / 2);
                phase_p  <= '0;
                en_p     <= (RESET_EN != 0);
                pend_r   <= 1'b0;
                cnt      <= '0;
                lock_cnt <= LOCK_INIT;
                clk_r    <= 1'b0;
                tick_r   <= 1'b0;
                lock_r   <= 1'b0;
            end else begin
                if (accept) begin
                    div_p   <= norm_div;
                    high_p  <= cfg_high;
                    phase_p <= norm_phase;
                    en_p    <= cfg_en;
                    pend_r  <= 1'b1;
                end

                if (en_a) begin
                    clk_r  <= (cnt < high_a);
                    tick_r <= (cnt == '0);
                end else begin
                    clk_r  <= 1'b0;
                    tick_r <= 1'b0;
                end

                if (apply) begin
                    div_a    <= div_p;
                    high_a   <= high_p;
                    phase_a  <= phase_p;
                    en_a     <= en_p;
                    cnt      <= phase_p;
                    pend_r   <= 1'b0;
                    lock_r   <= 1'b0;
                    lock_cnt <= LOCK_INIT;
                end else if (!en_a) begin
                    cnt      <= '0;
                    lock_r   <= 1'b0;
                    lock_cnt <= LOCK_INIT;
                end else begin
                    if (sync_i) begin
                        cnt <= phase_a;
                    end else if (at_boundary) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                    // Lock counts down and then saturates; lock rises on the
                    // edge that consumes the last count.
                    if (lock_cnt != '0) begin
                        lock_cnt <= lock_cnt - LK_W'(1);
                    end
                    lock_r <= (lock_cnt <= LK_W'(1));
                end
            end
        end
    end

endmodule
